// File: rtl/div8_seq.sv
// ---------------------------------------------------------------------------
// div8_seq : sequential unsigned restoring divider, one quotient bit per clock
//
// A multi-cycle functional unit that sits beside the ALU. Operands are latched
// when a start is accepted. Results are held until the next operation
// completes.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; results of the last operation are held
// CALC  | iterating; one trial subtraction per edge, WIDTH edges in total
// DONE  | one cycle; done_o high, results valid; a start here is accepted
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         asynchronous, active-high reset
//   start_i       request; sampled only in IDLE or DONE
//   dividend_i    unsigned dividend, sampled on an accepted start
//   divisor_i     unsigned divisor, sampled on an accepted start
//   busy_o        high while iterating (CALC)
//   done_o        one-cycle pulse; quotient/remainder/dbz valid
//   dbz_o         divide-by-zero flag for the last operation
//   quotient_o    unsigned quotient (all ones on divide by zero)
//   remainder_o   unsigned remainder (dividend on divide by zero)
// ---------------------------------------------------------------------------
module div8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             dbz_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int             CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] r_q,      r_d;
    logic [WIDTH-1:0] q_q,      q_d;
    logic [WIDTH-1:0] dvsr_q,   dvsr_d;
    logic [WIDTH-1:0] quot_q,   quot_d;
    logic [WIDTH-1:0] rem_q,    rem_d;
    logic             dbz_q,    dbz_d;

    logic             accept;
    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b_n;
    logic [WIDTH+1:0] trial_sum;
    logic             carry;
    logic             borrow;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;

    // A start is only looked at when the unit is not iterating.
    assign accept = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Trial subtraction {R, Q msb} - {0, divisor} as a + ~b + 1 on a
    // WIDTH+1 bit chain; the extra top bit of trial_sum is the carry-out.
    assign trial_a   = {r_q, q_q[WIDTH-1]};
    assign trial_b_n = ~{1'b0, dvsr_q};
    assign trial_sum = {1'b0, trial_a} + {1'b0, trial_b_n} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign carry     = trial_sum[WIDTH+1];

    // Since R < divisor on entry, a successful subtraction always fits in
    // WIDTH bits. A set bit WIDTH would mean R overflowed, so treat it like
    // a borrow and keep the shifted partial remainder instead.
    assign borrow = ~carry | trial_sum[WIDTH];

    assign r_step = borrow ? trial_a[WIDTH-1:0] : trial_sum[WIDTH-1:0];
    assign q_step = {q_q[WIDTH-2:0], ~borrow};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (divisor_i == '0) begin
                        // No iterations needed; results land on the next edge.
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = dividend_i;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        r_d     = '0;
                        q_d     = dividend_i;
                        dvsr_d  = divisor_i;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                    end
                end
            end

            S_CALC: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                    quot_d  = q_step;
                    rem_d   = r_step;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy_o      = (state_q == S_CALC);
    assign done_o      = (state_q == S_DONE);
    assign dbz_o       = dbz_q;
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;

endmodule

// File: tb/tb_div8_seq.sv
module tb_div8_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'd0;
    logic [7:0] divisor = 8'd0;
    logic       busy;
    logic       done;
    logic       dbz;
    logic [7:0] quotient;
    logic [7:0] remainder;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] prev_q   = 8'd0;
    logic [7:0] prev_r   = 8'd0;
    logic       prev_dbz = 1'b0;

    always #5 clk = ~clk;

    div8_seq #(.WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .busy_o      (busy),
        .done_o      (done),
        .dbz_o       (dbz),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Issue one operation at a negedge and follow it to its done cycle.
    // Returns at the negedge of the done cycle. Optionally injects a start
    // with other operands at cycle inj_k after acceptance (must be ignored).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input int inj_k, input logic [7:0] ia, input logic [7:0] ib);
        logic [7:0] eq, er;
        logic       edbz;
        int         elat, ebusy, lat, busy_cnt;
        bit         seen;
        if (b == 8'd0) begin
            eq = 8'hFF; er = a; edbz = 1'b1; elat = 1; ebusy = 0;
        end else begin
            eq = a / b; er = a % b; edbz = 1'b0; elat = 9; ebusy = 8;
        end
        lat = 0; busy_cnt = 0; seen = 0;
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1;
                lat  = k;
            end else begin
                chk("hold_quot", 32'(quotient), 32'(prev_q));
                chk("hold_rem", 32'(remainder), 32'(prev_r));
            end
            if (inj_k != 0 && k == inj_k) begin
                start = 1'b1; dividend = ia; divisor = ib;
            end else if (inj_k != 0 && k == inj_k + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", 32'(lat), 32'(elat));
            chk("busy_cycles", 32'(busy_cnt), 32'(ebusy));
            chk("quotient", 32'(quotient), 32'(eq));
            chk("remainder", 32'(remainder), 32'(er));
            chk("dbz", 32'(dbz), 32'(edbz));
            if (b != 8'd0) begin
                chk("invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                chk("rem_lt_div", 32'(remainder < b), 32'd1);
            end
        end
        prev_q = eq; prev_r = er; prev_dbz = edbz;
    endtask

    // One idle cycle after a done: done must have dropped, results held.
    task automatic gap();
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_quot", 32'(quotient), 32'(prev_q));
        chk("idle_rem", 32'(remainder), 32'(prev_r));
        chk("idle_dbz", 32'(dbz), 32'(prev_dbz));
    endtask

    task automatic count_dones(input string tag, input int cycles);
        int n;
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk(tag, 32'(n), 32'd0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(dbz), 32'd0);
        chk("rst_quot", 32'(quotient), 32'd0);
        chk("rst_rem", 32'(remainder), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        count_dones("idle_no_done", 3);
        gap();

        // Basic operation, then back-to-back starts in the done cycle.
        run_op(8'd200, 8'd7, 0, 8'd0, 8'd0);
        run_op(8'd255, 8'd1, 0, 8'd0, 8'd0);
        run_op(8'd5, 8'd9, 0, 8'd0, 8'd0);
        gap();

        // Divide by zero, then a normal operation clears dbz.
        run_op(8'd100, 8'd0, 0, 8'd0, 8'd0);
        gap();
        run_op(8'd9, 8'd3, 0, 8'd0, 8'd0);
        gap();

        // A start while busy is ignored; no second done follows.
        run_op(8'd200, 8'd7, 3, 8'd50, 8'd5);
        count_dones("no_second_done", 12);

        // Asynchronous reset in the middle of an operation.
        dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 4; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_dbz", 32'(dbz), 32'd0);
        chk("arst_quot", 32'(quotient), 32'd0);
        chk("arst_rem", 32'(remainder), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_q = 8'd0; prev_r = 8'd0; prev_dbz = 1'b0;
        count_dones("arst_no_done", 12);
        run_op(8'd13, 8'd4, 0, 8'd0, 8'd0);
        gap();

        // Random sweep with corner operands and random back-to-back issue.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 8'd0;
                1:       ra = 8'd255;
                default: ra = 8'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 8'd0;
                1:       rb = 8'd1;
                2:       rb = 8'd255;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            run_op(ra, rb, 0, 8'd0, 8'd0);
            if ($urandom_range(0, 1) == 0) gap();
        end
        gap();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
